// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode types: instruction and address widths, NOP encoding, queue entry layout.
// Imported by the fetch queue and by the decoder.
package fetch_queue_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [ILEN-1:0] instr_t;

  // addi x0, x0, 0 -- harmless opcode shown to decode while the queue is empty
  localparam instr_t NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

  function automatic addr_t pc_next(input addr_t pc);
    return pc + addr_t'(4);
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: instruction memory port, execute-stage redirect and decode handshake.
// master = fetch queue, slave = surrounding pipeline and memory.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  addr_t  imem_addr;
  logic   imem_req;
  instr_t imem_rdata;
  logic   PCSrcE;
  addr_t  PCTargetE;
  instr_t InstrD;
  addr_t  PCD;
  addr_t  PCPlus4D;
  logic   ValidD;
  logic   ReadyD;

  modport master (
    output imem_addr, imem_req, InstrD, PCD, PCPlus4D, ValidD,
    input  imem_rdata, PCSrcE, PCTargetE, ReadyD
  );

  modport slave (
    input  imem_addr, imem_req, InstrD, PCD, PCPlus4D, ValidD,
    output imem_rdata, PCSrcE, PCTargetE, ReadyD
  );
endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with single-cycle flush; head data is combinational from storage.
// Zero-latency read of head, push visible one cycle later, flush overrides push and pop.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == '0);
  assign full       = (count_q == (AW+1)'(DEPTH));
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetch PC, credit-checked memory requests, redirect flush, decode-facing FIFO head.
// First instruction reaches ValidD two cycles after its request; ReadyD low stalls the head, issue stops once slots are committed.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master fq
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  addr_t           pc_q, pc_d;
  logic            inflight_q, inflight_d;
  addr_t           inflight_pc_q, inflight_pc_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  fq_entry_t       head;
  fq_entry_t       push_entry;
  logic [CW:0]     committed;
  logic            issue;
  logic            push;
  logic            pop;

  // Credit counts only registered state, so a same-cycle pop never unblocks issue.
  assign committed = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign issue     = rst && !fq.PCSrcE && (committed < DEPTH_L);

  // A response landing in a redirect cycle belongs to the wrong path.
  assign push = inflight_q && !fq.PCSrcE;
  assign pop  = fq.ValidD && fq.ReadyD;

  assign push_entry = '{instr: fq.imem_rdata, pc: inflight_pc_q};
  assign head       = fq_entry_t'(fifo_head);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_entry),
    .pop_i      (pop),
    .flush_i    (fq.PCSrcE),
    .head_dat_o (fifo_head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (fq.PCSrcE) begin
      pc_d = fq.PCTargetE;
    end else if (issue) begin
      pc_d          = pc_next(pc_q);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign fq.imem_addr = pc_q;
  assign fq.imem_req  = issue;
  assign fq.ValidD    = !fifo_empty;
  assign fq.InstrD    = fifo_empty ? NOP_INSTR : head.instr;
  assign fq.PCD       = fifo_empty ? addr_t'(0) : head.pc;
  assign fq.PCPlus4D  = pc_next(fq.PCD);
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, stall/credit, redirects, PC wrap and async reset.
// dut1 starts at PC 0, dut2 at 0xFFFF_FFF8; each has its own one-cycle-latency memory.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  fetch_queue_if fq1 ();
  fetch_queue_if fq2 ();

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut1 (
    .clk (clk),
    .rst (rst),
    .fq  (fq1)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk (clk),
    .rst (rst),
    .fq  (fq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h00AB_0000;
  endfunction

  always @(posedge clk) begin
    if (fq1.imem_req) fq1.imem_rdata <= mem_word(fq1.imem_addr);
    if (fq2.imem_req) fq2.imem_rdata <= mem_word(fq2.imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  logic [31:0] wrap_pc  [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  logic [31:0] wrap_pc4 [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    fq1.ReadyD = 1'b1; fq1.PCSrcE = 1'b0; fq1.PCTargetE = '0;
    fq2.ReadyD = 1'b1; fq2.PCSrcE = 1'b0; fq2.PCTargetE = '0;

    repeat (2) @(negedge clk);
    check("rst_valid",  32'(fq1.ValidD),  32'h0);
    check("rst_instr",  fq1.InstrD,       32'h0000_0013);
    check("rst_pcd",    fq1.PCD,          32'h0);
    check("rst_pc4",    fq1.PCPlus4D,     32'h4);
    check("rst_req",    32'(fq1.imem_req), 32'h0);
    check("rst_addr",   fq1.imem_addr,    32'h0);
    check("rst_addr2",  fq2.imem_addr,    32'hFFFF_FFF8);

    // Streaming with ReadyD high: cycle 0 is the interval right after release.
    rst = 1'b1;
    #1;
    check("c0_req",   32'(fq1.imem_req), 32'h1);
    check("c0_addr",  fq1.imem_addr,     32'h0);
    check("c0_addr2", fq2.imem_addr,     32'hFFFF_FFF8);
    @(negedge clk);
    check("c1_valid", 32'(fq1.ValidD), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("seq_valid", 32'(fq1.ValidD), 32'h1);
      check("seq_pcd",   fq1.PCD,         32'(4 * i));
      check("seq_instr", fq1.InstrD,      mem_word(32'(4 * i)));
      check("seq_pc4",   fq1.PCPlus4D,    32'(4 * i + 4));
      if (i < 3) begin
        check("wrap_pcd", fq2.PCD,      wrap_pc[i]);
        check("wrap_pc4", fq2.PCPlus4D, wrap_pc4[i]);
      end
    end

    // Stall: head 20 holds; 24,28,32 fill the queue and fetch stops at 36.
    fq1.ReadyD = 1'b0;
    repeat (10) @(negedge clk);
    check("stall_valid", 32'(fq1.ValidD),   32'h1);
    check("stall_pcd",   fq1.PCD,           32'd20);
    check("stall_req",   32'(fq1.imem_req), 32'h0);
    check("stall_addr",  fq1.imem_addr,     32'd36);
    fq1.ReadyD = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(fq1.ValidD), 32'h1);
      check("drain_pcd",   fq1.PCD,         32'(20 + 4 * i));
      @(negedge clk);
    end

    // Redirect with three entries queued and one request inflight.
    fq1.ReadyD = 1'b0;
    @(negedge clk);
    check("pre_redir_pcd", fq1.PCD,           32'd52);
    check("pre_redir_req", 32'(fq1.imem_req), 32'h0);
    fq1.PCSrcE = 1'b1; fq1.PCTargetE = 32'h0000_0100;
    @(negedge clk);
    fq1.PCSrcE = 1'b0; fq1.ReadyD = 1'b1;
    #1;
    check("redir_valid", 32'(fq1.ValidD),   32'h0);
    check("redir_addr",  fq1.imem_addr,     32'h100);
    check("redir_req",   32'(fq1.imem_req), 32'h1);
    @(negedge clk);
    check("redir_c1_valid", 32'(fq1.ValidD), 32'h0);
    @(negedge clk);
    check("redir_c2_valid", 32'(fq1.ValidD), 32'h1);
    check("redir_c2_pcd",   fq1.PCD,         32'h100);
    check("redir_c2_instr", fq1.InstrD,      mem_word(32'h100));

    // Redirect coinciding with a pop of 0x104 and the 0x108 response.
    @(negedge clk);
    check("pop_redir_pcd", fq1.PCD, 32'h104);
    fq1.PCSrcE = 1'b1; fq1.PCTargetE = 32'h0000_0200;
    #1;
    check("pop_redir_req", 32'(fq1.imem_req), 32'h0);
    @(negedge clk);
    fq1.PCSrcE = 1'b0;
    #1;
    check("pr_valid", 32'(fq1.ValidD),   32'h0);
    check("pr_addr",  fq1.imem_addr,     32'h200);
    check("pr_req",   32'(fq1.imem_req), 32'h1);
    @(negedge clk);
    check("pr_c1_valid", 32'(fq1.ValidD), 32'h0);
    @(negedge clk);
    check("pr_c2_pcd", fq1.PCD,      32'h200);
    check("pr_c2_pc4", fq1.PCPlus4D, 32'h204);
    @(negedge clk);
    check("pr_c3_pcd", fq1.PCD, 32'h204);

    // Fill the queue, then pull reset between clock edges.
    fq1.ReadyD = 1'b0;
    repeat (6) @(negedge clk);
    check("full_valid", 32'(fq1.ValidD),   32'h1);
    check("full_pcd",   fq1.PCD,           32'h204);
    check("full_addr",  fq1.imem_addr,     32'h214);
    check("full_req",   32'(fq1.imem_req), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(fq1.ValidD),   32'h0);
    check("arst_instr", fq1.InstrD,        32'h0000_0013);
    check("arst_pcd",   fq1.PCD,           32'h0);
    check("arst_req",   32'(fq1.imem_req), 32'h0);
    check("arst_addr",  fq1.imem_addr,     32'h0);
    @(negedge clk);
    rst = 1'b1; fq1.ReadyD = 1'b1;
    #1;
    check("restart_req",  32'(fq1.imem_req), 32'h1);
    check("restart_addr", fq1.imem_addr,     32'h0);
    repeat (2) @(negedge clk);
    check("restart_valid", 32'(fq1.ValidD), 32'h1);
    check("restart_pcd",   fq1.PCD,         32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
